game_sprite_motion: RTL and testbench

Generates the moving bounding box (left/right/top/bottom) and target_enable for one game sprite; it is the producer side of the collision interface. Position advances once per frame_tick with edge bounce. The registered overlap result from the collision checker is consumed and drives a HIT sequence, after which the sprite returns to IDLE. One instance per moving object, between the frame timing logic and the collision checker.

---
 rtl/game_sprite_motion.sv | 174 +++++++++++++++++
 tb/tb_game_sprite_motion.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sprite_motion.sv
// rtl/game_sprite_motion.sv - moving sprite bounding box with edge bounce and hit sequence
// Optional GAME_SPRITE_HIT_BLINK_EN adds a 'visible' output that blinks while in HIT.
module game_sprite_motion #(
   parameter int screen_width  = 640,
   parameter int screen_height = 480,
   parameter int w_x           = $clog2(screen_width),
   parameter int w_y           = $clog2(screen_height),
   parameter int sprite_width  = 32,
   parameter int sprite_height = 16,
   parameter int start_x       = 0,
   parameter int start_y       = 100,
   parameter int speed_x       = 4,
   parameter int speed_y       = 2,
   parameter int hit_frames    = 30
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           launch,
   input  logic           frame_tick,
   input  logic           overlap,
   output logic [w_x-1:0] left,
   output logic [w_x-1:0] right,
   output logic [w_y-1:0] top,
   output logic [w_y-1:0] bottom,
`ifdef GAME_SPRITE_HIT_BLINK_EN
   output logic           visible,
`endif
   output logic           target_enable,
   output logic           hit,
   output logic           busy
);

   localparam int w_c = (hit_frames > 1) ? $clog2(hit_frames) : 1;

   localparam logic [w_x:0]   x_max   = (w_x+1)'(screen_width - sprite_width);
   localparam logic [w_y:0]   y_max   = (w_y+1)'(screen_height - sprite_height);
   localparam logic [w_x:0]   step_x  = (w_x+1)'(speed_x);
   localparam logic [w_y:0]   step_y  = (w_y+1)'(speed_y);
   localparam logic [w_x-1:0] x_start = w_x'(start_x);
   localparam logic [w_y-1:0] y_start = w_y'(start_y);
   localparam logic [w_x-1:0] x_span  = w_x'(sprite_width - 1);
   localparam logic [w_y-1:0] y_span  = w_y'(sprite_height - 1);
   localparam logic [w_c-1:0] c_last  = w_c'(hit_frames - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HIT} state_t;

   state_t         state;
   logic           dir_x;
   logic           dir_y;
   logic [w_c-1:0] cnt;
   logic [w_x:0]   sum_x;
   logic [w_y:0]   sum_y;
   logic [w_x-1:0] nx;
   logic [w_y-1:0] ny;
   logic           ndx;
   logic           ndy;

   // One-bit-wider sums so the clamp test cannot wrap near the far edge.
   always_comb begin
      sum_x = {1'b0, left} + step_x;
      sum_y = {1'b0, top} + step_y;
      nx    = left;
      ny    = top;
      ndx   = dir_x;
      ndy   = dir_y;
      if (dir_x) begin
         if (sum_x >= x_max) begin
            nx  = x_max[w_x-1:0];
            ndx = 1'b0;
         end else begin
            nx = sum_x[w_x-1:0];
         end
      end else if ({1'b0, left} <= step_x) begin
         nx  = '0;
         ndx = 1'b1;
      end else begin
         nx = left - step_x[w_x-1:0];
      end
      if (dir_y) begin
         if (sum_y >= y_max) begin
            ny  = y_max[w_y-1:0];
            ndy = 1'b0;
         end else begin
            ny = sum_y[w_y-1:0];
         end
      end else if ({1'b0, top} <= step_y) begin
         ny  = '0;
         ndy = 1'b1;
      end else begin
         ny = top - step_y[w_y-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         left          <= x_start;
         right         <= x_start + x_span;
         top           <= y_start;
         bottom        <= y_start + y_span;
         dir_x         <= 1'b1;
         dir_y         <= 1'b1;
         cnt           <= '0;
         target_enable <= 1'b0;
         hit           <= 1'b0;
         busy          <= 1'b0;
`ifdef GAME_SPRITE_HIT_BLINK_EN
         visible       <= 1'b0;
`endif
      end else begin
         hit <= 1'b0;
         case (state)
            S_IDLE: begin
               if (launch) begin
                  state         <= S_ACTIVE;
                  left          <= x_start;
                  right         <= x_start + x_span;
                  top           <= y_start;
                  bottom        <= y_start + y_span;
                  dir_x         <= 1'b1;
                  dir_y         <= 1'b1;
                  target_enable <= 1'b1;
                  busy          <= 1'b1;
`ifdef GAME_SPRITE_HIT_BLINK_EN
                  visible       <= 1'b1;
`endif
               end
            end
            S_ACTIVE: begin
               // A collision takes priority over a same-cycle frame move.
               if (overlap) begin
                  state         <= S_HIT;
                  hit           <= 1'b1;
                  target_enable <= 1'b0;
                  cnt           <= '0;
`ifdef GAME_SPRITE_HIT_BLINK_EN
                  visible       <= 1'b1;
`endif
               end else if (frame_tick) begin
                  left   <= nx;
                  right  <= nx + x_span;
                  top    <= ny;
                  bottom <= ny + y_span;
                  dir_x  <= ndx;
                  dir_y  <= ndy;
               end
            end
            S_HIT: begin
               if (frame_tick) begin
                  if (cnt == c_last) begin
                     state   <= S_IDLE;
                     left    <= x_start;
                     right   <= x_start + x_span;
                     top     <= y_start;
                     bottom  <= y_start + y_span;
                     cnt     <= '0;
                     busy    <= 1'b0;
`ifdef GAME_SPRITE_HIT_BLINK_EN
                     visible <= 1'b0;
`endif
                  end else begin
                     cnt     <= cnt + 1'b1;
`ifdef GAME_SPRITE_HIT_BLINK_EN
                     visible <= ~visible;
`endif
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_sprite_motion.sv
// tb/tb_game_sprite_motion.sv - self-checking bench for game_sprite_motion
module tb_game_sprite_motion;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic launch = 1'b0;
   logic frame_tick = 1'b0;
   logic overlap = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] l[3];
   logic [9:0] r[3];
   logic [8:0] t[3];
   logic [8:0] b[3];
   logic       te[3];
   logic       hp[3];
   logic       bz[3];
`ifdef GAME_SPRITE_HIT_BLINK_EN
   logic       vis[3];
`endif

   int checks = 0;
   int failures = 0;

   // Reference model: one entry per instance (defaults / near far edges / narrow, hit_frames=1)
   int sx[3] = '{0, 600, 602};
   int sy[3] = '{100, 460, 100};
   int sw[3] = '{32, 32, 30};
   int hf[3] = '{30, 30, 1};
   int mode[3];
   int mx[3];
   int my[3];
   int mdx[3];
   int mdy[3];
   int mcnt[3];
   bit mhit[3];

   game_sprite_motion u_a (
      .clk(clk), .rst_n(rst_n), .launch(launch), .frame_tick(frame_tick), .overlap(overlap),
`ifdef GAME_SPRITE_HIT_BLINK_EN
      .visible(vis[0]),
`endif
      .left(l[0]), .right(r[0]), .top(t[0]), .bottom(b[0]),
      .target_enable(te[0]), .hit(hp[0]), .busy(bz[0]));

   game_sprite_motion #(.start_x(600), .start_y(460)) u_b (
      .clk(clk), .rst_n(rst_n), .launch(launch), .frame_tick(frame_tick), .overlap(overlap),
`ifdef GAME_SPRITE_HIT_BLINK_EN
      .visible(vis[1]),
`endif
      .left(l[1]), .right(r[1]), .top(t[1]), .bottom(b[1]),
      .target_enable(te[1]), .hit(hp[1]), .busy(bz[1]));

   game_sprite_motion #(.start_x(602), .sprite_width(30), .hit_frames(1)) u_c (
      .clk(clk), .rst_n(rst_n), .launch(launch), .frame_tick(frame_tick), .overlap(overlap),
`ifdef GAME_SPRITE_HIT_BLINK_EN
      .visible(vis[2]),
`endif
      .left(l[2]), .right(r[2]), .top(t[2]), .bottom(b[2]),
      .target_enable(te[2]), .hit(hp[2]), .busy(bz[2]));

   function automatic logic [40:0] obs(int i);
      return {l[i], r[i], t[i], b[i], te[i], hp[i], bz[i]};
   endfunction

   function automatic logic [40:0] expv(int i);
      return {10'(mx[i]), 10'(mx[i] + sw[i] - 1), 9'(my[i]), 9'(my[i] + 15),
              mode[i] == 1, mhit[i], mode[i] != 0};
   endfunction

   // Signed displacement, then clamp to [0, lim] and reverse on contact.
   task automatic bounce(input int pos, input int d, input int sp, input int lim,
                         output int npos, output int nd);
      int p;
      p = pos + d * sp;
      nd = d;
      if (p >= lim) begin npos = lim; nd = -1; end
      else if (p <= 0) begin npos = 0; nd = 1; end
      else npos = p;
   endtask

   task automatic model_step(input bit rs, input bit ln, input bit ft, input bit ov);
      for (int i = 0; i < 3; i++) begin
         mhit[i] = 1'b0;
         if (!rs) begin
            mode[i] = 0; mx[i] = sx[i]; my[i] = sy[i]; mdx[i] = 1; mdy[i] = 1; mcnt[i] = 0;
         end else if (mode[i] == 0) begin
            if (ln) begin
               mode[i] = 1; mx[i] = sx[i]; my[i] = sy[i]; mdx[i] = 1; mdy[i] = 1;
            end
         end else if (mode[i] == 1) begin
            if (ov) begin
               mode[i] = 2; mhit[i] = 1'b1; mcnt[i] = 0;
            end else if (ft) begin
               bounce(mx[i], mdx[i], 4, 640 - sw[i], mx[i], mdx[i]);
               bounce(my[i], mdy[i], 2, 480 - 16, my[i], mdy[i]);
            end
         end else if (ft) begin
            if (mcnt[i] == hf[i] - 1) begin
               mode[i] = 0; mx[i] = sx[i]; my[i] = sy[i]; mcnt[i] = 0;
            end else begin
               mcnt[i]++;
            end
         end
      end
   endtask

   task automatic cyc(input bit rs, input bit ln, input bit ft, input bit ov);
      rst_n = rs; launch = ln; frame_tick = ft; overlap = ov;
      @(posedge clk);
      model_step(rs, ln, ft, ov);
      #1;
      rst_n = 1'b1; launch = 1'b0; frame_tick = 1'b0; overlap = 1'b0;
   endtask

   task automatic test_reset;
      cyc(0, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs(i) !== expv(i)) begin
            failures++;
            $display("FAIL reset inst%0d got=%h exp=%h", i, obs(i), expv(i));
         end
      end
      checks++;
      if ({l[0], r[0], t[0], b[0], te[0], bz[0], hp[0]} !== {10'd0, 10'd31, 9'd100, 9'd115, 3'b000}) begin
         failures++;
         $display("FAIL reset_values got=%0d/%0d/%0d/%0d te=%b busy=%b hit=%b exp=0/31/100/115 0 0 0",
                  l[0], r[0], t[0], b[0], te[0], bz[0], hp[0]);
      end
   endtask

   task automatic test_launch_move;
      int exp_l[3] = '{604, 608, 604};
      int exp_t[3] = '{462, 464, 462};
      cyc(1, 1, 0, 0);
      checks++;
      if (te[0] !== 1'b1 || bz[0] !== 1'b1) begin
         failures++;
         $display("FAIL launch_enable got te=%b busy=%b exp te=1 busy=1", te[0], bz[0]);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 1, 0);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               failures++;
               $display("FAIL move inst%0d tick%0d got=%h exp=%h", i, k, obs(i), expv(i));
            end
         end
         checks++;
         if (int'(l[1]) != exp_l[k] || int'(t[1]) != exp_t[k]) begin
            failures++;
            $display("FAIL far_edge tick%0d got left=%0d top=%0d exp left=%0d top=%0d",
                     k, l[1], t[1], exp_l[k], exp_t[k]);
         end
      end
      checks++;
      if ({l[0], r[0], t[0], b[0]} !== {10'd12, 10'd43, 9'd106, 9'd121}) begin
         failures++;
         $display("FAIL three_ticks got=%0d/%0d/%0d/%0d exp=12/43/106/121", l[0], r[0], t[0], b[0]);
      end
   endtask

   task automatic test_hit;
      cyc(1, 0, 1, 1);
      checks++;
      if (hp[0] !== 1'b1 || te[0] !== 1'b0 || l[0] !== 10'd12) begin
         failures++;
         $display("FAIL hit_entry got hit=%b te=%b left=%0d exp hit=1 te=0 left=12", hp[0], te[0], l[0]);
      end
      cyc(1, 1, 0, 0);
      checks++;
      if (hp[0] !== 1'b0 || bz[0] !== 1'b1 || te[0] !== 1'b0) begin
         failures++;
         $display("FAIL hit_pulse got hit=%b busy=%b te=%b exp 0 1 0", hp[0], bz[0], te[0]);
      end
      for (int k = 1; k <= 30; k++) begin
         cyc(1, k == 5, 1, 0);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               failures++;
               $display("FAIL hit_seq inst%0d tick%0d got=%h exp=%h", i, k, obs(i), expv(i));
            end
         end
         if (k == 29) begin
            checks++;
            if (bz[0] !== 1'b1 || l[0] !== 10'd12) begin
               failures++;
               $display("FAIL hit_hold got busy=%b left=%0d exp busy=1 left=12", bz[0], l[0]);
            end
         end
      end
      checks++;
      if (bz[0] !== 1'b0 || l[0] !== 10'd0 || t[0] !== 9'd100) begin
         failures++;
         $display("FAIL hit_exit got busy=%b left=%0d top=%0d exp busy=0 left=0 top=100", bz[0], l[0], t[0]);
      end
   endtask

   task automatic test_left_bounce;
      bit found = 1'b0;
      cyc(1, 1, 0, 0);
      for (int n = 0; n < 400 && !found; n++) begin
         if (mode[2] == 1 && mx[2] == 2 && mdx[2] < 0) found = 1'b1;
         else begin
            cyc(1, 0, 1, 0);
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (obs(i) !== expv(i)) begin
                  failures++;
                  $display("FAIL bounce_run inst%0d got=%h exp=%h", i, obs(i), expv(i));
               end
            end
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL bounce_reach got=timeout exp=left 2 moving down");
      end
      cyc(1, 0, 1, 0);
      checks++;
      if (l[2] !== 10'd0) begin
         failures++;
         $display("FAIL left_clamp got=%0d exp=0", l[2]);
      end
      cyc(1, 0, 1, 0);
      checks++;
      if (l[2] !== 10'd4) begin
         failures++;
         $display("FAIL left_rebound got=%0d exp=4", l[2]);
      end
   endtask

   task automatic test_reset_mid_hit;
      cyc(1, 0, 0, 1);
      for (int k = 0; k < 10; k++) cyc(1, 0, 1, 0);
      cyc(0, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs(i) !== expv(i)) begin
            failures++;
            $display("FAIL mid_hit_reset inst%0d got=%h exp=%h", i, obs(i), expv(i));
         end
      end
      checks++;
      if (l[0] !== 10'd0 || t[0] !== 9'd100 || bz[0] !== 1'b0 || te[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_hit_state got left=%0d top=%0d busy=%b te=%b exp 0 100 0 0", l[0], t[0], bz[0], te[0]);
      end
      cyc(1, 1, 0, 0);
      cyc(1, 0, 1, 0);
      checks++;
      if (te[0] !== 1'b1 || l[0] !== 10'd4 || t[0] !== 9'd102) begin
         failures++;
         $display("FAIL relaunch got te=%b left=%0d top=%0d exp 1 4 102", te[0], l[0], t[0]);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 600; n++) begin
         cyc($urandom_range(99) != 0, $urandom_range(7) == 0,
             $urandom_range(2) == 0, $urandom_range(15) == 0);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
               failures++;
               $display("FAIL random inst%0d cyc%0d got=%h exp=%h", i, n, obs(i), expv(i));
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_launch_move;
      test_hit;
      test_left_bounce;
      test_reset_mid_hit;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
